// File: rtl/soc_system_pio_led_ext.sv
// Avalon-MM output PIO driving WIDTH LED/GPIO pins, with atomic set/clear/toggle
// registers and a per-bit hardware blink engine clocked by a programmable period.
module soc_system_pio_led_ext #(
    parameter int unsigned WIDTH          = 4,
    parameter logic [31:0] RESET_VALUE    = 32'd4,
    parameter int unsigned PERIOD_W       = 24,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrBlinkEn  = 3'd1;
    localparam logic [2:0] AddrPeriod   = 3'd2;
    localparam logic [2:0] AddrStatus   = 3'd3;
    localparam logic [2:0] AddrOutSet   = 3'd4;
    localparam logic [2:0] AddrOutClear = 3'd5;
    localparam logic [2:0] AddrToggle   = 3'd6;

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_en_q, blink_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                phase_q, phase_d;

    logic                wr;
    logic [WIDTH-1:0]    wd_bits;
    logic [PERIOD_W-1:0] wd_period;
    logic                unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_bits   = writedata[WIDTH-1:0];
    assign wd_period = writedata[PERIOD_W-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        if (wr) begin
            case (address)
                AddrData:     data_d     = wd_bits;
                AddrBlinkEn:  blink_en_d = wd_bits;
                AddrOutSet:   data_d     = data_q | wd_bits;
                AddrOutClear: data_d     = data_q & ~wd_bits;
                AddrToggle:   data_d     = data_q ^ wd_bits;
                default:      ;
            endcase
        end
    end

    // A PERIOD write restarts the blink cycle and wins over a coincident terminal count.
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        phase_d  = phase_q;
        if (wr && address == AddrPeriod) begin
            period_d = wd_period;
            count_d  = '0;
            phase_d  = 1'b1;
        end else if (period_q == '0) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (count_q == period_q - PERIOD_W'(1)) begin
            count_d = '0;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE[WIDTH-1:0];
            blink_en_q <= '0;
            period_q   <= DEFAULT_PERIOD[PERIOD_W-1:0];
            count_q    <= '0;
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            count_q    <= count_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            AddrData:    readdata[WIDTH-1:0]    = data_q;
            AddrBlinkEn: readdata[WIDTH-1:0]    = blink_en_q;
            AddrPeriod:  readdata[PERIOD_W-1:0] = period_q;
            AddrStatus:  readdata[0]            = phase_q;
            default:     readdata               = '0;
        endcase
    end

    // Blinking bits are gated by phase; the output depends on flops only.
    assign out_port = data_q & (~blink_en_q | {WIDTH{phase_q}});

endmodule

// File: tb/tb_soc_system_pio_led_ext.sv
// Self-checking bench for soc_system_pio_led_ext: directed scenarios plus randomized
// bus traffic against a cycle-count-based reference model.
module tb_soc_system_pio_led_ext;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: registers plus the cycle at which the blink cycle last restarted.
    int unsigned cyc      = 0;
    int unsigned m_data   = 0;
    int unsigned m_en     = 0;
    int unsigned m_period = 0;
    int unsigned m_epoch  = 0;

    soc_system_pio_led_ext #(
        .WIDTH         (W),
        .RESET_VALUE   (32'd4),
        .PERIOD_W      (PW),
        .DEFAULT_PERIOD(32'd0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    function automatic int unsigned mdl_phase();
        if (m_period == 0) return 1;
        return (((cyc - m_epoch) / m_period) % 2 == 0) ? 1 : 0;
    endfunction

    function automatic logic [W-1:0] mdl_out();
        logic [W-1:0] d, e;
        d = W'(m_data);
        e = W'(m_en);
        return mdl_phase() != 0 ? d : (d & ~e);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_data;
            3'd1:    return m_en;
            3'd2:    return m_period;
            3'd3:    return mdl_phase();
            default: return 0;
        endcase
    endfunction

    function automatic void mdl_apply(input bit rst, input bit wr, input logic [2:0] a,
                                      input logic [31:0] wd);
        int unsigned v;
        v = wd & ((1 << W) - 1);
        if (rst) begin
            m_data = 4; m_en = 0; m_period = 0; m_epoch = cyc;
        end else if (wr) begin
            case (a)
                3'd0: m_data = v;
                3'd1: m_en = v;
                3'd2: begin m_period = wd & 32'h00FF_FFFF; m_epoch = cyc; end
                3'd4: m_data = m_data | v;
                3'd5: m_data = m_data & ~v;
                3'd6: m_data = m_data ^ v;
                default: ;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One clock with the given bus/reset values; model follows, then the bus goes idle.
    task automatic cycle(input bit rst, input bit cs, input bit wn, input logic [2:0] a,
                         input logic [31:0] wd);
        reset_n = ~rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
        tick();
        mdl_apply(rst, cs & ~wn, a, wd);
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
        cycle(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h4, 32'h0, 32'h0, 32'h1};
        cycle(1'b1, 1'b0, 1'b1, 3'd0, '0);
        cycle(1'b1, 1'b0, 1'b1, 3'd0, '0);
        n_checks++;
        if (out_port !== 4'b0100) $display("FAIL reset_out: got %h exp %h", out_port, 4'b0100);
        else n_pass++;
        for (int a = 0; a < 4; a++) begin
            peek(3'(a), v);
            n_checks++;
            if (v !== exp_rd[a]) $display("FAIL reset_read%0d: got %h exp %h", a, v, exp_rd[a]);
            else n_pass++;
        end
    endtask

    task automatic test_atomic();
        logic [31:0] v;
        logic [2:0]  ops  [3] = '{3'd4, 3'd5, 3'd6};
        logic [31:0] wds  [3] = '{32'h3, 32'h2, 32'hF};
        logic [3:0]  exps [3] = '{4'h7, 4'h5, 4'hA};
        for (int i = 0; i < 3; i++) begin
            bus_write(ops[i], wds[i]);
            n_checks++;
            if (out_port !== exps[i] || out_port !== mdl_out())
                $display("FAIL atomic_out%0d: got %h exp %h", i, out_port, exps[i]);
            else n_pass++;
            peek(3'd0, v);
            n_checks++;
            if (v !== 32'(exps[i])) $display("FAIL atomic_data%0d: got %h exp %h", i, v, exps[i]);
            else n_pass++;
            peek(ops[i], v);
            n_checks++;
            if (v !== 32'h0) $display("FAIL atomic_wo_read%0d: got %h exp 0", i, v);
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        logic [31:0] v;
        logic        pat [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        bus_write(3'd0, 32'hF);
        bus_write(3'd1, 32'h1);
        bus_write(3'd2, 32'd3);
        for (int k = 0; k < 12; k++) begin
            peek(3'd3, v);
            n_checks++;
            if (out_port[0] !== pat[k] || out_port !== mdl_out() || out_port[3:1] !== 3'b111
                || v !== 32'(out_port[0]))
                $display("FAIL blink_k%0d: got out=%h status=%h exp bit0=%0d", k, out_port, v,
                         pat[k]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_period_collision();
        logic [31:0] v;
        bus_write(3'd2, 32'd3);
        tick();
        tick();
        bus_write(3'd2, 32'd5);
        for (int k = 0; k < 10; k++) begin
            peek(3'd3, v);
            n_checks++;
            if (v !== ((k < 5) ? 32'd1 : 32'd0) || v !== mdl_read(3'd3))
                $display("FAIL collision_k%0d: got phase %h exp %0d", k, v, (k < 5));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_chipselect();
        logic [31:0] v;
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'h5);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'hF);
        peek(3'd0, v);
        n_checks++;
        if (v !== 32'h5 || out_port !== 4'h5)
            $display("FAIL chipselect_gate: got data=%h out=%h exp 5", v, out_port);
        else n_pass++;
    endtask

    task automatic test_reset_mid_blink();
        logic [31:0] v;
        bus_write(3'd0, 32'hF);
        bus_write(3'd1, 32'hF);
        bus_write(3'd2, 32'd2);
        tick();
        tick();
        peek(3'd3, v);
        n_checks++;
        if (v !== 32'h0 || out_port !== 4'h0)
            $display("FAIL midblink_phase0: got phase=%h out=%h exp 0", v, out_port);
        else n_pass++;
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        n_checks++;
        if (out_port !== 4'h4) $display("FAIL midblink_out: got %h exp 4", out_port);
        else n_pass++;
        for (int a = 1; a < 4; a++) begin
            peek(3'(a), v);
            n_checks++;
            if (v !== ((a == 3) ? 32'h1 : 32'h0))
                $display("FAIL midblink_read%0d: got %h exp %0d", a, v, (a == 3));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] v, wd;
        logic [2:0]  a;
        bit          rst, cs, wn;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 2) == 0);
            a   = 3'($urandom_range(0, 7));
            wd  = $urandom();
            if (a == 3'd2) wd = (wd & 32'hFF00_0000) | $urandom_range(0, 5);
            cycle(rst, cs, wn, a, wd);
            peek(3'($urandom_range(0, 7)), v);
            n_checks++;
            if (out_port !== mdl_out() || v !== mdl_read(address))
                $display("FAIL random_i%0d: got out=%h rd[%0d]=%h exp out=%h rd=%h", i, out_port,
                         address, v, mdl_out(), mdl_read(address));
            else n_pass++;
        end
    endtask

    initial begin
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        test_reset();
        test_atomic();
        test_blink();
        test_period_collision();
        test_chipselect();
        test_reset_mid_blink();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
